// File: rtl/alu_result_stage_pkg.sv
// Shared CPU definitions: bus widths, ALU opcodes, flag bit positions and the
// result-stage payload struct.
package alu_result_stage_pkg;

  localparam int unsigned DATABUS_SIZE     = 8;
  localparam int unsigned ALU_CONTROL_SIZE = 4;
  localparam int unsigned RegIdxW          = 5;

  typedef logic [ALU_CONTROL_SIZE-1:0] alu_op_t;

  localparam alu_op_t ADD  = 4'd0;
  localparam alu_op_t ADDC = 4'd1;
  localparam alu_op_t SUB  = 4'd2;
  localparam alu_op_t SUBC = 4'd3;
  localparam alu_op_t AND  = 4'd4;
  localparam alu_op_t OR   = 4'd5;
  localparam alu_op_t XOR  = 4'd6;
  localparam alu_op_t NOT  = 4'd7;
  localparam alu_op_t SHL  = 4'd8;
  localparam alu_op_t SHR  = 4'd9;
  localparam alu_op_t BEQ  = 4'd10;
  localparam alu_op_t BNE  = 4'd11;
  localparam alu_op_t BLT  = 4'd12;

  localparam int unsigned ZERO     = 0;
  localparam int unsigned CARRY    = 1;
  localparam int unsigned OVERFLOW = 2;
  localparam int unsigned SIGN     = 3;

  typedef struct packed {
    logic [DATABUS_SIZE-1:0] z;
    logic [RegIdxW-1:0]      dest;
    logic                    wb_en;
    logic                    br_valid;
    logic                    br_taken;
  } alu_result_t;

  function automatic logic is_branch(alu_op_t op);
    return (op == BEQ) || (op == BNE) || (op == BLT);
  endfunction

endpackage

// File: rtl/alu_result_stage_skid_buffer2.sv
// skid_buffer2: generic 2-entry valid/ready FIFO with registered head output
// and a synchronous clear that wins over both push and pop.
module skid_buffer2 #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic [1:0]       count_q, count_d;
  logic [Width-1:0] head_q, head_d;
  logic [Width-1:0] skid_q, skid_d;
  logic             push, pop;

  assign in_ready_o  = (count_q != 2'(Depth));
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

  assign push = in_valid_i & in_ready_o & ~clear_i;
  assign pop  = out_valid_o & out_ready_i;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = in_data_i;
          else                 skid_d = in_data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = skid_q;
          count_d = count_q - 2'd1;
        end
        // Only reachable with one entry: the new item replaces the departing head.
        2'b11: head_d = in_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: buffers ALU results, classifies branches and
// holds the architectural flags. Optional sticky overflow: ALU_STAGE_STICKY_OV_EN.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int unsigned DEST_W = RegIdxW,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATABUS_SIZE-1:0]     in_z,
  input  logic [3:0]                  in_flags,
  input  logic [ALU_CONTROL_SIZE-1:0] in_op,
  input  logic [DEST_W-1:0]           in_dest,
  input  logic                        in_flag_we,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATABUS_SIZE-1:0]     out_z,
  output logic [DEST_W-1:0]           out_dest,
  output logic                        out_wb_en,
  output logic                        out_br_valid,
  output logic                        out_br_taken,
  output logic [3:0]                  flags_q,
  output logic                        carry_out
`ifdef ALU_STAGE_STICKY_OV_EN
  ,
  input  logic                        ov_clear,
  output logic                        ov_sticky
`endif
);

  alu_result_t in_entry, head;
  logic        in_is_br;
  logic        push;
  logic [3:0]  flags_d;

  assign in_is_br = is_branch(in_op);

  always_comb begin
    in_entry          = '0;
    in_entry.z        = in_z;
    in_entry.dest     = in_dest;
    in_entry.wb_en    = ~in_is_br;
    in_entry.br_valid = in_is_br;
    in_entry.br_taken = in_is_br & in_z[0];
  end

  skid_buffer2 #(
    .Width($bits(alu_result_t)),
    .Depth(DEPTH)
  ) u_buf (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_entry),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (head)
  );

  // Stale head contents must not look like a writeback or branch once drained.
  assign out_z        = head.z;
  assign out_dest     = head.dest;
  assign out_wb_en    = out_valid & head.wb_en;
  assign out_br_valid = out_valid & head.br_valid;
  assign out_br_taken = out_valid & head.br_taken;

  assign push = in_valid & in_ready & ~flush;

  always_comb begin
    flags_d = flags_q;
    if (push && in_flag_we) flags_d = in_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0;
    else        flags_q <= flags_d;
  end

  assign carry_out = flags_q[CARRY];

`ifdef ALU_STAGE_STICKY_OV_EN
  logic ov_sticky_q, ov_sticky_d;

  always_comb begin
    ov_sticky_d = ov_sticky_q;
    if (ov_clear) ov_sticky_d = 1'b0;
    if (push && in_flag_we && in_flags[OVERFLOW]) ov_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ov_sticky_q <= 1'b0;
    else        ov_sticky_q <= ov_sticky_d;
  end

  assign ov_sticky = ov_sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_alu_result_stage;
  import alu_result_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_z;
  logic [3:0]  in_flags;
  alu_op_t     in_op;
  logic [4:0]  in_dest;
  logic        in_flag_we;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_z;
  logic [4:0]  out_dest;
  logic        out_wb_en;
  logic        out_br_valid;
  logic        out_br_taken;
  logic [3:0]  flags_q;
  logic        carry_out;
`ifdef ALU_STAGE_STICKY_OV_EN
  logic        ov_clear;
  logic        ov_sticky;
  logic        mdl_ov;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_result_t exp_q[$];
  logic [3:0]  mdl_flags;
  logic        mdl_ready;
  logic        mdl_valid;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_z        (in_z),
    .in_flags    (in_flags),
    .in_op       (in_op),
    .in_dest     (in_dest),
    .in_flag_we  (in_flag_we),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_z       (out_z),
    .out_dest    (out_dest),
    .out_wb_en   (out_wb_en),
    .out_br_valid(out_br_valid),
    .out_br_taken(out_br_taken),
    .flags_q     (flags_q),
    .carry_out   (carry_out)
`ifdef ALU_STAGE_STICKY_OV_EN
    ,
    .ov_clear    (ov_clear),
    .ov_sticky   (ov_sticky)
`endif
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_result_t expect_entry(logic [7:0] z, logic [4:0] d, alu_op_t op);
    alu_result_t r;
    logic br;
    br = (op == BEQ) || (op == BNE) || (op == BLT);
    r.z        = z;
    r.dest     = d;
    r.wb_en    = !br;
    r.br_valid = br;
    r.br_taken = br && z[0];
    return r;
  endfunction

  // Reference model: accepts items and tracks flags at each rising edge.
  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        exp_q.delete();
      end else if (in_valid && mdl_ready) begin
        exp_q.push_back(expect_entry(in_z, in_dest, in_op));
        if (in_flag_we) mdl_flags = in_flags;
      end
`ifdef ALU_STAGE_STICKY_OV_EN
      if (ov_clear) mdl_ov = 1'b0;
      if (!flush && in_valid && mdl_ready && in_flag_we && in_flags[OVERFLOW]) mdl_ov = 1'b1;
`endif
    end
  end

  // Monitor: compares at the falling edge, retires the head on a handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      mdl_ready = (exp_q.size() != 2);
      mdl_valid = (exp_q.size() != 0);
      check("in_ready", in_ready, mdl_ready);
      check("out_valid", out_valid, mdl_valid);
      if (mdl_valid) begin
        check("out_z", out_z, exp_q[0].z);
        check("out_dest", out_dest, exp_q[0].dest);
        check("out_wb_en", out_wb_en, exp_q[0].wb_en);
        check("out_br_valid", out_br_valid, exp_q[0].br_valid);
        check("out_br_taken", out_br_taken, exp_q[0].br_taken);
      end else begin
        check("idle_wb_en", out_wb_en, 1'b0);
        check("idle_br_valid", out_br_valid, 1'b0);
      end
      check("flags_q", flags_q, mdl_flags);
      check("carry_out", carry_out, mdl_flags[CARRY]);
`ifdef ALU_STAGE_STICKY_OV_EN
      check("ov_sticky", ov_sticky, mdl_ov);
`endif
    end
  end

  always @(posedge clk) begin
    if (rst_n && mdl_valid && out_ready && !flush && exp_q.size() != 0) exp_q.pop_front();
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic apply(logic v, alu_op_t op, logic [7:0] z, logic [4:0] d,
                       logic [3:0] f, logic fwe);
    in_valid   = v;
    in_op      = op;
    in_z       = z;
    in_dest    = d;
    in_flags   = f;
    in_flag_we = fwe;
    flush      = 1'b0;
  endtask

  task automatic wait_accept(string name);
    int guard = 0;
    while (!mdl_ready && guard < 50) begin
      tick();
      guard++;
    end
    n_checks++;
    if (!mdl_ready) begin
      n_fail++;
      $display("FAIL %s: accept timeout, got in_ready=%0b expected 1", name, in_ready);
    end
  endtask

  task automatic send(string name, alu_op_t op, logic [7:0] z, logic [4:0] d,
                      logic [3:0] f, logic fwe);
    tick();
    apply(1'b1, op, z, d, f, fwe);
    wait_accept(name);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    mdl_flags = 4'b0;
    mdl_ready = 1'b1;
    mdl_valid = 1'b0;
`ifdef ALU_STAGE_STICKY_OV_EN
    mdl_ov = 1'b0;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    apply(1'b0, ADD, 8'h0, 5'd0, 4'h0, 1'b0);
    out_ready = 1'b0;
`ifdef ALU_STAGE_STICKY_OV_EN
    ov_clear = 1'b0;
`endif
    do_reset();
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_flags", flags_q, 4'b0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Single pass.
    tick();
    out_ready = 1'b1;
    send("single", ADD, 8'h05, 5'd3, 4'h0, 1'b0);
    idle(3);

    // Backpressure: A and B fill the buffer, C waits.
    out_ready = 1'b0;
    send("bp_a", SUB, 8'hA1, 5'd1, 4'h0, 1'b0);
    send("bp_b", XOR, 8'hB2, 5'd2, 4'h0, 1'b0);
    tick();
    apply(1'b1, OR, 8'hC3, 5'd4, 4'h0, 1'b0);
    repeat (3) tick();
    out_ready = 1'b1;
    wait_accept("bp_c");
    idle(4);

    // Carry chain.
    send("carry_add", ADD, 8'h10, 5'd5, 4'b0010, 1'b1);
    send("carry_and", AND, 8'h20, 5'd6, 4'b0000, 1'b0);
    idle(2);
    check("carry_held", carry_out, 1'b1);

    // Branch outcomes.
    send("beq", BEQ, 8'h01, 5'd7, 4'h0, 1'b0);
    send("bne", BNE, 8'h00, 5'd8, 4'h0, 1'b0);
    send("blt", BLT, 8'h03, 5'd9, 4'h0, 1'b0);
    idle(3);

    // Flush with a full buffer and a concurrent flag-writing push.
    out_ready = 1'b0;
    send("fl_a", ADD, 8'h11, 5'd10, 4'b0001, 1'b1);
    send("fl_b", SUB, 8'h22, 5'd11, 4'b0000, 1'b0);
    tick();
    apply(1'b1, ADD, 8'h33, 5'd12, 4'b1000, 1'b1);
    flush = 1'b1;
    idle(1);
    check("flush_flags", flags_q, 4'b0001);
    out_ready = 1'b1;
    idle(2);

    // Asynchronous reset with two entries buffered.
    out_ready = 1'b0;
    send("rst_a", ADDC, 8'h44, 5'd13, 4'b0110, 1'b1);
    send("rst_b", SUBC, 8'h55, 5'd14, 4'b0000, 1'b0);
    idle(1);
    #3;
    do_reset();
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_in_ready", in_ready, 1'b1);
    check("async_flags", flags_q, 4'b0);
    check("async_out_z", out_z, 8'h0);
    tick();
    rst_n = 1'b1;
    idle(1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      tick();
      apply($urandom_range(0, 3) != 0, alu_op_t'($urandom_range(0, 12)), 8'($urandom),
            5'($urandom), 4'($urandom), 1'($urandom));
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_STAGE_STICKY_OV_EN
      ov_clear  = ($urandom_range(0, 9) == 0);
`endif
    end
    out_ready = 1'b1;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
